serial_tx: RTL and testbench
============================

// Module: serial_tx
//
// PURPOSE
//   Parallel-in, serial-out frame transmitter: the driving end of the bit-serial
//   link whose receive side is a clocked chain of D flip-flops (SIPO).
//   Accepts a WIDTH-bit word over a valid/ready handshake.
//   Emits it on txd as one frame: start bit (0), data LSB-first, then STOP_BITS
//   stop bits (1). Each bit is held DIV clocks.
//   Sits between the CPU I/O port and the front-panel/peripheral serial chain.
//
// PARAMETERS
//   WIDTH      8   data bits per frame (>=1)
//   DIV        4   clocks per bit (>=1)
//   STOP_BITS  1   stop bits per frame (1 or 2)
//   FANOUT_TXD 3   loads on txd; passed to the output driver stage
//
// PORTS
//   clk    in   1      clock; all state changes on rising edge
//   clr    in   1      reset, asynchronous, active-low
//   data   in   WIDTH  word to send; sampled only on the accept edge
//   valid  in   1      word present on data
//   ready  out  1      transmitter idle, can accept
//   txd    out  1      serial line; idles high (mark)
//   busy   out  1      frame in progress (== ~ready)
//
// BEHAVIOUR
//   - Reset (clr=0, any time, no clock needed):
//     state=IDLE, txd=1, ready=1, busy=0, shift reg=0, counters=0.
//   - Accept: rising edge with valid=1 & ready=1; call this edge E0.
//     data is copied to the shift reg.
//     valid with ready=0 is ignored; data changes after E0 are ignored.
//   - States: IDLE -> START -> DATA -> STOP -> IDLE.
//     IDLE : txd=1, ready=1.
//     START: entered at E0; txd=0 for DIV clocks.
//     DATA : bit k driven from edge E0+(1+k)*DIV, k=0..WIDTH-1; shift reg >>1 per bit.
//     STOP : txd=1 from E0+(1+WIDTH)*DIV for STOP_BITS*DIV clocks.
//     IDLE re-entered at edge E0+(1+WIDTH+STOP_BITS)*DIV; ready=1 from that edge.
//   - Frame length: exactly (1+WIDTH+STOP_BITS)*DIV clocks; ready=0 throughout.
//   - Back-to-back: with valid held high, the next accept occurs on the edge
//     after ready rises, giving exactly one idle clock (txd=1) between frames.
//   - Divider counter: 0..DIV-1, wraps to 0 on each bit boundary.
//     Bit counter: 0..WIDTH-1. Widths are $clog2 of range, minimum 1.
//   - DIV=1: the divider is constant; every clock is a bit boundary.
//   - txd is registered: no combinational path from data/valid to txd.
//   - clr low mid-frame aborts at once: txd=1, ready=1.
//     No partial frame resumes after clr returns high.
//
// STRUCTURE
//   - Shared include serial_defs.vh holds:
//     state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
//     line levels MARK=1'b1, SPACE=1'b0.
//     The matching receiver uses the same include.
//   - One sub-module: bit_timer.
//     Params DIV; ports clk, clr, run, tick.
//     tick pulses on the last clock of each bit period; held at 0 while run=0.
//   - The FSM, shift reg and bit counter live in serial_tx itself.
//
// TESTING
//   1. clr=0 with clk stopped -> txd=1, ready=1, busy=0 immediately.
//      Release clr, valid=0 for 10 clks -> txd stays 1.
//   2. WIDTH=8, DIV=4, data=8'hA5, 1-clk valid pulse -> txd = 0x4, then
//      1,0,1,0,0,1,0,1 each x4, then 1x4. ready=0 for exactly 40 clks.
//   3. valid held, data=8'h00, then 8'hFF queued -> second start bit begins one
//      clk after ready rises. Changing data mid-frame does not alter bits sent.
//   4. clr pulsed low during data bit 3 of 8'hF0 -> txd=1, ready=1 without a clock
//      edge. Next accept of 8'h3C -> complete, correct 40-clk frame.
//   5. WIDTH=5, DIV=1, STOP_BITS=2, data=5'h16 -> txd=0,0,1,1,0,1,1,1.
//      Frame is 8 clks.
//   6. valid toggled every clk while busy -> no second accept, no frame corruption.
//      Check txd against a reference SIPO receiver model.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_tx_pkg
//
// Shared definitions for the bit-serial link (transmitter and matching SIPO
// receiver):
//   - tx_state_e : frame sequencer states, fixed encodings so both ends of the
//                  link and any debug tap agree on the numeric values.
//   - MARK/SPACE : line levels. The line idles at MARK; a start bit is SPACE.
//   - cnt_width  : register width for a counter spanning 0..range-1. A counter
//                  always has at least one bit, even when range is 1.
// -----------------------------------------------------------------------------
package serial_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam logic MARK  = 1'b1;
   localparam logic SPACE = 1'b0;

   function automatic int cnt_width(input int range);
      return (range > 1) ? $clog2(range) : 1;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage : serial_tx_pkg

// File: rtl/serial_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
//
// Divides the clock into bit periods of DIV clocks. While run is high the
// divider counts 0..DIV-1 and wraps; tick is high during the last clock of
// each period, so the edge that ends the period is the bit boundary. While
// run is low the divider is parked at 0 and tick stays low, so the first
// period after run rises is a full DIV clocks long.
//
// Ports
//   clk   in   1   clock, rising edge
//   clr   in   1   asynchronous reset, active low
//   run   in   1   count enable (high while a frame is on the line)
//   tick  out  1   high on the last clock of each bit period
// -----------------------------------------------------------------------------
module bit_timer
   import serial_tx_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam int              CW   = cnt_width(DIV);
   localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

   logic [CW-1:0] div_cnt_q;
   logic [CW-1:0] div_cnt_d;

   // With DIV=1, LAST is 0: the divider never leaves 0 and every clock with
   // run high is a bit boundary.
   assign tick = run && (div_cnt_q == LAST);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      div_cnt_d = div_cnt_q;
      if (!run) begin
         div_cnt_d = '0;
      end else if (div_cnt_q == LAST) begin
         div_cnt_d = '0;
      end else begin
         div_cnt_d = div_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of statement or process order.
      if (!clr) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule : bit_timer

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
//
// Parallel-in, serial-out frame transmitter for the bit-serial peripheral
// chain. A WIDTH-bit word is accepted over valid/ready and sent on txd as
//   start bit (SPACE), WIDTH data bits LSB first, STOP_BITS stop bits (MARK),
// each bit held DIV clocks. A frame occupies exactly
// (1 + WIDTH + STOP_BITS) * DIV clocks, during which ready is low.
//
// With valid held high, the next word is accepted on the edge after ready
// rises, which leaves exactly one idle (MARK) clock between frames.
//
// txd comes straight from a flop, so there is no combinational path from
// data/valid to the line. Pulling clr low aborts any frame at once; the line
// returns to MARK and the partial frame is discarded.
//
// Parameters
//   WIDTH       data bits per frame (>= 1)
//   DIV         clocks per bit (>= 1)
//   STOP_BITS   stop bits per frame (1 or 2)
//   FANOUT_TXD  loads on txd, handed to the output driver stage
//
// Ports
//   clk    in   1      clock, rising edge
//   clr    in   1      asynchronous reset, active low
//   data   in   WIDTH  word to send, sampled only on the accept edge
//   valid  in   1      word present on data
//   ready  out  1      idle, can accept a word
//   txd    out  1      serial line, idles high
//   busy   out  1      frame in progress (inverse of ready)
// -----------------------------------------------------------------------------
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DIV        = 4,
   parameter int STOP_BITS  = 1,
   parameter int FANOUT_TXD = 3
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] data,
   input  logic             valid,
   output logic             ready,
   output logic             txd,
   output logic             busy
);

   // Parameter sanity: reject configurations the sequencer cannot produce.
   if (WIDTH < 1) begin : g_bad_width
      $error("serial_tx: WIDTH must be >= 1");
   end
   if (DIV < 1) begin : g_bad_div
      $error("serial_tx: DIV must be >= 1");
   end
   if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
      $error("serial_tx: STOP_BITS must be 1 or 2");
   end
   if (FANOUT_TXD < 1) begin : g_bad_fanout
      $error("serial_tx: FANOUT_TXD must be >= 1");
   end

   // The bit counter indexes data bits (0..WIDTH-1) and is reused to count
   // stop bits, so it must cover whichever range is larger.
   localparam int               BCW       = cnt_width(max_int(WIDTH, STOP_BITS));
   localparam logic [BCW-1:0]   LAST_DATA = BCW'(WIDTH - 1);
   localparam logic [BCW-1:0]   LAST_STOP = BCW'(STOP_BITS - 1);

   tx_state_e        state_q;
   tx_state_e        state_d;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] shift_d;
   logic [BCW-1:0]   bit_cnt_q;
   logic [BCW-1:0]   bit_cnt_d;
   logic             txd_q;
   logic             txd_d;

   logic             run;
   logic             tick;
   logic             accept;

   assign ready  = (state_q == IDLE);
   assign busy   = ~ready;
   assign txd    = txd_q;
   assign accept = valid && ready;
   assign run    = (state_q != IDLE);

   bit_timer #(
      .DIV (DIV)
   ) u_bit_timer (
      .clk  (clk),
      .clr  (clr),
      .run  (run),
      .tick (tick)
   );

   // Next-state and next-line logic. txd_d is the level the line takes from
   // the coming edge onward, so each transition loads the level of the bit
   // that starts at that edge.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      txd_d     = txd_q;

      case (state_q)
         IDLE: begin
            txd_d = MARK;
            if (accept) begin
               shift_d   = data;
               bit_cnt_d = '0;
               txd_d     = SPACE;
               state_d   = START;
            end
         end

         START: begin
            if (tick) begin
               txd_d   = shift_q[0];
               shift_d = shift_q >> 1;
               state_d = DATA;
            end
         end

         DATA: begin
            if (tick) begin
               if (bit_cnt_q == LAST_DATA) begin
                  txd_d     = MARK;
                  bit_cnt_d = '0;
                  state_d   = STOP;
               end else begin
                  // shift_q[0] already holds the next bit: the register was
                  // shifted when the current bit was put on the line.
                  txd_d     = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end

         STOP: begin
            txd_d = MARK;
            if (tick) begin
               if (bit_cnt_q == LAST_STOP) begin
                  bit_cnt_d = '0;
                  state_d   = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end

         default: begin
            txd_d   = MARK;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         txd_q     <= MARK;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         txd_q     <= txd_d;
      end
   end

endmodule : serial_tx

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx
//
// Two transmitters share one clock: dut8 (WIDTH=8, DIV=4, STOP_BITS=1) and
// dut5 (WIDTH=5, DIV=1, STOP_BITS=2). The expected line level for every clock
// of a frame is computed from the frame layout (start, data LSB first, stops,
// each DIV clocks); a SIPO receiver model samples mid-bit and rebuilds the
// word. Inputs change at falling edges, outputs are sampled at falling edges.
// -----------------------------------------------------------------------------
module tb_serial_tx;

   localparam int W8 = 8;
   localparam int D8 = 4;
   localparam int S8 = 1;
   localparam int L8 = (1 + W8 + S8) * D8;

   localparam int W5 = 5;
   localparam int D5 = 1;
   localparam int S5 = 2;
   localparam int L5 = (1 + W5 + S5) * D5;

   logic          clk;
   logic          clk_en;
   logic          clr8;
   logic          clr5;

   logic [W8-1:0] data8;
   logic          valid8;
   logic          ready8;
   logic          txd8;
   logic          busy8;

   logic [W5-1:0] data5;
   logic          valid5;
   logic          ready5;
   logic          txd5;
   logic          busy5;

   int            n_checks;
   int            n_fail;

   serial_tx #(
      .WIDTH      (W8),
      .DIV        (D8),
      .STOP_BITS  (S8),
      .FANOUT_TXD (3)
   ) dut8 (
      .clk   (clk),
      .clr   (clr8),
      .data  (data8),
      .valid (valid8),
      .ready (ready8),
      .txd   (txd8),
      .busy  (busy8)
   );

   serial_tx #(
      .WIDTH      (W5),
      .DIV        (D5),
      .STOP_BITS  (S5),
      .FANOUT_TXD (3)
   ) dut5 (
      .clk   (clk),
      .clr   (clr5),
      .data  (data5),
      .valid (valid5),
      .ready (ready5),
      .txd   (txd5),
      .busy  (busy5)
   );

   initial clk = 1'b0;
   always #5 if (clk_en) clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Line level at clock 'cycle' (0 = clock after the accept edge) of a frame.
   function automatic logic exp_bit(input int w, input int d,
                                    input logic [31:0] word, input int cycle);
      int b;
      b = cycle / d;
      if (b == 0) return 1'b0;
      if (b <= w) return word[b-1];
      return 1'b1;
   endfunction

   // One frame on dut8. Called at a falling edge while dut8 is idle.
   // mode 0: one-clock valid pulse; 1: valid held high (back-to-back);
   // 2: valid toggled every clock while busy. data is scrambled every clock
   // after the accept edge in all modes.
   task automatic frame8(input logic [W8-1:0] word, input int mode,
                         input string tag);
      int            low_cnt;
      logic          rx_bits[$];
      logic [W8-1:0] rx_word;
      low_cnt = 0;
      check({tag, "_pre_ready"}, ready8, 1);
      data8  = word;
      valid8 = 1'b1;
      for (int i = 0; i < L8; i++) begin
         @(negedge clk);
         check({tag, "_txd"}, txd8, exp_bit(W8, D8, word, i));
         if (ready8 === 1'b0 && busy8 === 1'b1) low_cnt++;
         if (i % D8 == D8 / 2) rx_bits.push_back(txd8);
         data8 = W8'($urandom);
         if (mode == 0 && i == 0) valid8 = 1'b0;
         if (mode == 2) valid8 = ~valid8;
      end
      @(negedge clk);
      check({tag, "_gap_ready"}, ready8, 1);
      check({tag, "_gap_txd"}, txd8, 1);
      check({tag, "_gap_busy"}, busy8, 0);
      check({tag, "_busy_clks"}, low_cnt, L8);
      for (int k = 0; k < W8; k++) rx_word[k] = rx_bits[1 + k];
      check({tag, "_rx_start"}, rx_bits[0], 0);
      check({tag, "_rx_word"}, rx_word, word);
      check({tag, "_rx_stop"}, rx_bits[1 + W8], 1);
      if (mode == 2) valid8 = 1'b0;
   endtask

   // One frame on dut5 with a one-clock valid pulse.
   task automatic frame5(input logic [W5-1:0] word, input string tag);
      int            low_cnt;
      logic          rx_bits[$];
      logic [W5-1:0] rx_word;
      low_cnt = 0;
      check({tag, "_pre_ready"}, ready5, 1);
      data5  = word;
      valid5 = 1'b1;
      for (int i = 0; i < L5; i++) begin
         @(negedge clk);
         check({tag, "_txd"}, txd5, exp_bit(W5, D5, word, i));
         if (ready5 === 1'b0 && busy5 === 1'b1) low_cnt++;
         if (i % D5 == D5 / 2) rx_bits.push_back(txd5);
         data5 = W5'($urandom);
         if (i == 0) valid5 = 1'b0;
      end
      @(negedge clk);
      check({tag, "_gap_ready"}, ready5, 1);
      check({tag, "_gap_txd"}, txd5, 1);
      check({tag, "_busy_clks"}, low_cnt, L5);
      for (int k = 0; k < W5; k++) rx_word[k] = rx_bits[1 + k];
      check({tag, "_rx_start"}, rx_bits[0], 0);
      check({tag, "_rx_word"}, rx_word, word);
      check({tag, "_rx_stop1"}, rx_bits[1 + W5], 1);
      check({tag, "_rx_stop2"}, rx_bits[2 + W5], 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clk_en   = 1'b0;
      clr8     = 1'b1;
      clr5     = 1'b1;
      data8    = '0;
      valid8   = 1'b0;
      data5    = '0;
      valid5   = 1'b0;

      // Reset with the clock stopped: outputs settle without any edge.
      #1;
      clr8 = 1'b0;
      clr5 = 1'b0;
      #2;
      check("rst_txd8", txd8, 1);
      check("rst_ready8", ready8, 1);
      check("rst_busy8", busy8, 0);
      check("rst_txd5", txd5, 1);
      check("rst_ready5", ready5, 1);
      check("rst_busy5", busy5, 0);
      #2;
      clr8   = 1'b1;
      clr5   = 1'b1;
      clk_en = 1'b1;

      // Idle line with valid low.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_txd8", txd8, 1);
         check("idle_ready8", ready8, 1);
         check("idle_txd5", txd5, 1);
      end

      // Single frame, one-clock valid pulse.
      frame8(8'hA5, 0, "a5");

      // Back-to-back with valid held high; data scrambled mid-frame.
      frame8(8'h00, 1, "b2b_00");
      frame8(8'hFF, 1, "b2b_ff");
      valid8 = 1'b0;

      // Abort during data bit 3 of 8'hF0 (bit index 4 covers clocks 16..19).
      data8  = 8'hF0;
      valid8 = 1'b1;
      @(negedge clk);
      valid8 = 1'b0;
      repeat (17) @(negedge clk);
      check("abort_pre_txd", txd8, 0);
      check("abort_pre_ready", ready8, 0);
      #1;
      clr8 = 1'b0;
      #1;
      check("abort_txd", txd8, 1);
      check("abort_ready", ready8, 1);
      check("abort_busy", busy8, 0);
      #1;
      clr8 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("abort_no_resume", {txd8, ready8}, 2'b11);
      end
      frame8(8'h3C, 0, "after_abort");

      // Narrow word, one clock per bit, two stop bits.
      frame5(5'h16, "w5_16");

      // valid toggled every clock while busy.
      frame8(8'h5A, 2, "toggle");

      // Randomized words and handshake styles.
      for (int n = 0; n < 6; n++) begin
         frame8(W8'($urandom), int'($urandom_range(0, 2)), "rand8");
         valid8 = 1'b0;
      end
      for (int n = 0; n < 4; n++) begin
         frame5(W5'($urandom), "rand5");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule : tb_serial_tx
